pow_unit: RTL and testbench
===========================

Name: pow_unit

Overview:
- Parametrised integer power block. Computes end_out = x^n mod 2^WIDTH.
- Successor to the fixed 32-bit dataflow power graph.
- Adds configurable operand widths, a selectable algorithm (linear multiply or square-and-multiply), and full valid/ready handshakes with backpressure on both sides.
- Drops into dataflow graphs as a single elastic node between a start channel and an end channel.

Parameters:
- WIDTH, 32: width of x_din and end_out; all arithmetic is modulo 2^WIDTH.
- N_WIDTH, 8: width of the exponent n_din.
- ALGO, 1: 0 = linear (n multiply steps); 1 = square-and-multiply (one step per significant bit of n).

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- start_valid, input, 1: upstream offers an operand pair.
- start_ready, output, 1: block can accept an operand pair.
- x_din, input, WIDTH: base, sampled on the start handshake.
- n_din, input, N_WIDTH: exponent (unsigned), sampled on the start handshake.
- end_out, output, WIDTH: result.
- end_valid, output, 1: result available.
- end_ready, input, 1: downstream accepts the result.
- end_ovf, output, 1: present only with POW_OVF_FLAG_EN (see Optional Feature).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state = IDLE, start_ready = 1, end_valid = 0, end_out = 0, end_ovf = 0.
- Internal registers:
  - acc, base: WIDTH bits each.
  - e: N_WIDTH bits.
  - Linear step counter: N_WIDTH bits.
- State machine:
  - IDLE:
    - start_ready = 1.
    - On start_valid && start_ready at edge k: acc <= 1, base <= x_din, e <= n_din.
    - If n_din == 0, go to DONE; otherwise go to RUN.
  - RUN, ALGO = 1, each cycle:
    - If e[0], acc <= acc*base (low WIDTH bits).
    - base <= base*base (low WIDTH bits); e <= e >> 1.
    - When (e >> 1) == 0, go to DONE.
  - RUN, ALGO = 0, each cycle:
    - acc <= acc*base; e <= e - 1.
    - When e == 1, go to DONE.
  - DONE:
    - end_valid = 1, end_out = acc.
    - On end_ready, go to IDLE (end_valid drops next cycle).
    - While end_ready = 0, end_out and end_valid hold stable.
- start_ready is 0 in RUN and DONE. There is no overlap; one transaction is in flight at a time.
- Latency, for a handshake at edge k (count from edge k; end_valid first high after the stated edge):
  - n = 0: after edge k+1 (result 1 in both modes).
  - ALGO = 1: after edge k+1+B, where B = floor(log2 n) + 1.
  - ALGO = 0: after edge k+1+n.
- Operand rules:
  - x = 0 with n > 0 gives 0; 0^0 gives 1.
  - Products are truncated to WIDTH bits.
  - Exponent n = 2^N_WIDTH - 1 is legal; the counter must not wrap.
- Back-to-back transfers:
  - A result handshake at edge j followed by start_valid held high: the next start is accepted at edge j+1.
  - start_valid held high while busy is ignored, not queued.
- Reset mid-operation: the next edge forces IDLE and end_valid = 0; the partial result is discarded.
- x_din and n_din are don't-care outside the start handshake.

Optional Feature:
- Macro: POW_OVF_FLAG_EN.
- Defined:
  - end_ovf port exists; valid while end_valid = 1; cleared on every accepted start.
  - end_ovf = 1 iff the true x^n is >= 2^WIDTH.
  - Tracking rules:
    - Sticky flag set when any acc multiply's upper WIDTH product bits are nonzero.
    - A base_ovf sticky flag is set when base squaring overflows.
    - Multiplying acc by base while base_ovf = 1 (and acc != 0) also sets the flag.
- Undefined: no end_ovf port and no extra logic.

Test Plan:
- Reset, ALGO = 1: x = 2, n = 3 accepted at edge k -> end_out = 8, end_valid first high after edge k+3; start_ready low until the end handshake.
- n = 0, x = 123 -> end_out = 1 after edge k+1. Also x = 0, n = 5 -> end_out = 0.
- WIDTH = 32, x = 3:
  - n = 20 -> 0xCFD41B91, end_ovf = 0.
  - n = 21 -> 0x6F7C52B3, end_ovf = 1.
  - Both results identical with ALGO = 0; ALGO = 0 latency is 21 cycles.
- Backpressure: end_ready = 0 for 10 cycles after end_valid -> end_out stable, start_ready = 0. Then raise end_ready with start_valid held and a new pair (x = 5, n = 2) -> accepted the next edge, result 25.
- Reset mid-operation: assert rst during RUN of x = 7, n = 200 -> the next cycle shows end_valid = 0, start_ready = 1; a following x = 2, n = 10 -> 1024.
- Random: 1000 pairs, x in [0, 2^WIDTH - 1], n in [0, 2^N_WIDTH - 1], random end_ready -> each result matches a software model mod 2^WIDTH.

Source files
------------

// File: rtl/pow_unit.sv
// pow_unit: elastic integer power node, end_out = x^n mod 2^WIDTH.
// One operand pair in flight at a time. The start and end channels are
// valid/ready, and end_out/end_valid hold stable under backpressure.
// ALGO = 1 uses square-and-multiply (one step per significant bit of n).
// ALGO = 0 uses repeated multiplication (n steps).
// Optional: define POW_OVF_FLAG_EN to add end_ovf. It is high when the true
// x^n does not fit in WIDTH bits.
module pow_unit #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 8,
  parameter int ALGO    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WIDTH-1:0]   x_din,
  input  logic [N_WIDTH-1:0] n_din,
  output logic [WIDTH-1:0]   end_out,
  output logic               end_valid,
  input  logic               end_ready
`ifdef POW_OVF_FLAG_EN
  ,
  output logic               end_ovf
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   base;
  // e is the remaining exponent. In linear mode it also serves as the step
  // counter: it counts down to 1 and stops, so n = 2^N_WIDTH-1 never wraps.
  logic [N_WIDTH-1:0] e;

  logic [WIDTH-1:0]   acc_mul;
  logic [WIDTH-1:0]   base_sq;
  logic               step_mul;
  logic               last_step;

`ifdef POW_OVF_FLAG_EN
  logic [2*WIDTH-1:0] acc_full;
  logic [2*WIDTH-1:0] base_full;
  logic               ovf;
  logic               base_ovf;

  // The full-width products expose the bits lost to truncation.
  assign acc_full  = {{WIDTH{1'b0}}, acc}  * {{WIDTH{1'b0}}, base};
  assign base_full = {{WIDTH{1'b0}}, base} * {{WIDTH{1'b0}}, base};
  assign acc_mul   = acc_full[WIDTH-1:0];
  assign base_sq   = base_full[WIDTH-1:0];
`else
  assign acc_mul   = acc * base;
  assign base_sq   = base * base;
`endif

  // Square-and-multiply folds in base only on set exponent bits.
  // The linear mode multiplies on every step.
  assign step_mul  = (ALGO == 1) ? e[0] : 1'b1;
  assign last_step = (ALGO == 1) ? ((e >> 1) == '0) : (e == N_WIDTH'(1));

  assign start_ready = (state == IDLE);

  // Control FSM and datapath. The DONE state first registers the result
  // into end_out for one cycle, then presents it until end_ready accepts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register is reset here, so no stale partial result can
      // leak into end_out after a mid-operation reset.
      state     <= IDLE;
      acc       <= '0;
      base      <= '0;
      e         <= '0;
      end_out   <= '0;
      end_valid <= 1'b0;
`ifdef POW_OVF_FLAG_EN
      ovf       <= 1'b0;
      base_ovf  <= 1'b0;
      end_ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            acc   <= WIDTH'(1);
            base  <= x_din;
            e     <= n_din;
            state <= (n_din == '0) ? DONE : RUN;
`ifdef POW_OVF_FLAG_EN
            ovf      <= 1'b0;
            base_ovf <= 1'b0;
            end_ovf  <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (step_mul) begin
            acc <= acc_mul;
`ifdef POW_OVF_FLAG_EN
            // If acc is nonzero and base has already overflowed, the true
            // product overflows even when the truncated bits look small.
            if ((acc_full[2*WIDTH-1:WIDTH] != '0) ||
                (base_ovf && (acc != '0)))
              ovf <= 1'b1;
`endif
          end
          if (ALGO == 1) begin
            base <= base_sq;
            e    <= e >> 1;
`ifdef POW_OVF_FLAG_EN
            if (base_full[2*WIDTH-1:WIDTH] != '0)
              base_ovf <= 1'b1;
`endif
          end else begin
            e <= e - N_WIDTH'(1);
          end
          if (last_step)
            state <= DONE;
        end
        DONE: begin
          if (!end_valid) begin
            end_out   <= acc;
            end_valid <= 1'b1;
`ifdef POW_OVF_FLAG_EN
            end_ovf   <= ovf;
`endif
          end else if (end_ready) begin
            end_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pow_unit.sv
// tb_pow_unit: directed and random checks of pow_unit with WIDTH=32 and
// N_WIDTH=8.
// Index 0 is the square-and-multiply instance (ALGO=1).
// Index 1 is the linear instance (ALGO=0).
module tb_pow_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sv  [2];
  logic        sr  [2];
  logic [31:0] xd  [2];
  logic [7:0]  nd  [2];
  logic [31:0] eo  [2];
  logic        ev  [2];
  logic        er  [2];
  logic        ovf_w [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pow_unit #(.WIDTH(32), .N_WIDTH(8), .ALGO(1)) u_sq (
    .clk(clk), .rst(rst),
    .start_valid(sv[0]), .start_ready(sr[0]),
    .x_din(xd[0]), .n_din(nd[0]),
    .end_out(eo[0]), .end_valid(ev[0]), .end_ready(er[0])
`ifdef POW_OVF_FLAG_EN
    , .end_ovf(ovf_w[0])
`endif
  );

  pow_unit #(.WIDTH(32), .N_WIDTH(8), .ALGO(0)) u_lin (
    .clk(clk), .rst(rst),
    .start_valid(sv[1]), .start_ready(sr[1]),
    .x_din(xd[1]), .n_din(nd[1]),
    .end_out(eo[1]), .end_valid(ev[1]), .end_ready(er[1])
`ifdef POW_OVF_FLAG_EN
    , .end_ovf(ovf_w[1])
`endif
  );

`ifndef POW_OVF_FLAG_EN
  assign ovf_w[0] = 1'b0;
  assign ovf_w[1] = 1'b0;
`endif

  function automatic logic [31:0] model_pow(input logic [31:0] x, input int n);
    logic [31:0] r = 32'd1;
    for (int i = 0; i < n; i++) r = r * x;
    return r;
  endfunction

  function automatic bit model_ovf(input logic [31:0] x, input int n);
    logic [63:0] t = 64'd1;
    for (int i = 0; i < n; i++) begin
      t = t * {32'd0, x};
      if (t[63:32] != 32'd0) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int exp_lat(input int d, input int n);
    int b = 0;
    int m = n;
    if (n == 0) return 1;
    if (d == 1) return n + 1;
    while (m > 0) begin m = m >> 1; b++; end
    return b + 1;
  endfunction

  // Run one transaction on instance d. lat is the number of edges after the
  // start handshake until end_valid is first seen high.
  task automatic transact(input int d, input logic [31:0] x, input int n,
                          input bit rand_rdy, output logic [31:0] res,
                          output int lat, output bit ovf);
    int  k;
    bit  busy_bad;
    bit  hold_bad;
    bit  acc_done;
    @(negedge clk);
    sv[d] = 1'b1; xd[d] = x; nd[d] = 8'(n);
    er[d] = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    k = 0;
    while (!sr[d] && k < 300) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    sv[d] = 1'b0; xd[d] = $urandom; nd[d] = 8'($urandom);
    lat = 0; busy_bad = 1'b0;
    while (!ev[d] && lat < 300) begin
      if (sr[d]) busy_bad = 1'b1;
      @(posedge clk); #1; lat++;
    end
    n_tests++;
    if (!ev[d]) begin
      n_fail++;
      $display("FAIL timeout[%0d] x=%0d n=%0d: end_valid=%b required 1", d, x, n, ev[d]);
    end
    n_tests++;
    if (busy_bad) begin
      n_fail++;
      $display("FAIL busy_ready[%0d] x=%0d n=%0d: start_ready=1 while busy, required 0", d, x, n);
    end
    res = eo[d]; ovf = ovf_w[d];
    hold_bad = 1'b0; acc_done = 1'b0; k = 0;
    while (!acc_done && k < 100) begin
      @(negedge clk);
      er[d] = (rand_rdy && k < 50) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      if (er[d]) acc_done = 1'b1;
      else if (ev[d] !== 1'b1 || eo[d] !== res) hold_bad = 1'b1;
      k++;
    end
    n_tests++;
    if (hold_bad || ev[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL hold[%0d] x=%0d n=%0d: hold_bad=%b end_valid_after=%b required 0/0",
               d, x, n, hold_bad, ev[d]);
    end
    er[d] = 1'b1;
  endtask

  // Transaction with explicit expected values. exp_o is checked only when
  // the overflow flag exists.
  task automatic directed(input int d, input logic [31:0] x, input int n,
                          input logic [31:0] exp_r, input int exp_l, input bit exp_o);
    logic [31:0] r;
    int          l;
    bit          o;
    transact(d, x, n, 1'b0, r, l, o);
    n_tests++;
    if (r !== exp_r) begin
      n_fail++;
      $display("FAIL result[%0d] %0d^%0d: got 0x%08h required 0x%08h", d, x, n, r, exp_r);
    end
    n_tests++;
    if (l != exp_l) begin
      n_fail++;
      $display("FAIL latency[%0d] %0d^%0d: got %0d required %0d", d, x, n, l, exp_l);
    end
`ifdef POW_OVF_FLAG_EN
    n_tests++;
    if (o !== exp_o) begin
      n_fail++;
      $display("FAIL ovf[%0d] %0d^%0d: got %b required %b", d, x, n, o, exp_o);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (sr[d] !== 1'b1 || ev[d] !== 1'b0 || eo[d] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset[%0d]: ready=%b valid=%b out=%0d required 1/0/0", d, sr[d], ev[d], eo[d]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    directed(0, 32'd2,   3, 32'd8, 3, 1'b0);
    directed(0, 32'd123, 0, 32'd1, 1, 1'b0);
    directed(1, 32'd123, 0, 32'd1, 1, 1'b0);
    directed(0, 32'd0,   5, 32'd0, 4, 1'b0);
    directed(1, 32'd0,   0, 32'd1, 1, 1'b0);
    directed(1, 32'd2,  10, 32'd1024, 11, 1'b0);
  endtask

  task automatic test_pow3();
    directed(0, 32'd3, 20, 32'hCFD41B91, 6,  1'b0);
    directed(0, 32'd3, 21, 32'h6F7C52B3, 6,  1'b1);
    directed(1, 32'd3, 20, 32'hCFD41B91, 21, 1'b0);
    directed(1, 32'd3, 21, 32'h6F7C52B3, 22, 1'b1);
    directed(0, 32'h0001_0000, 2, 32'd0, 3, 1'b1);
    directed(0, 32'h0000_FFFF, 2, 32'hFFFE_0001, 3, 1'b0);
  endtask

  task automatic test_max_exp();
    directed(0, 32'd1, 255, 32'd1, 9,   1'b0);
    directed(1, 32'd1, 255, 32'd1, 256, 1'b0);
    // 3^255 mod 2^32 = 3 * (3^2)^127.
    directed(0, 32'd3, 255, model_pow(32'd3, 255), 9,   1'b1);
    directed(1, 32'hFFFFFFFF, 255, 32'hFFFFFFFF, 256, 1'b1);
  endtask

  task automatic test_backpressure();
    int  l;
    bit  bad;
    @(negedge clk);
    er[0] = 1'b0; sv[0] = 1'b1; xd[0] = 32'd2; nd[0] = 8'd4;
    @(posedge clk); #1;
    // Present the next pair immediately. It must be ignored while busy.
    sv[0] = 1'b1; xd[0] = 32'd5; nd[0] = 8'd2;
    l = 0;
    while (!ev[0] && l < 50) begin @(posedge clk); #1; l++; end
    n_tests++;
    if (eo[0] !== 32'd16 || l != 4) begin
      n_fail++;
      $display("FAIL bp_first: out=%0d lat=%0d required 16/4", eo[0], l);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ev[0] !== 1'b1 || eo[0] !== 32'd16 || sr[0] !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_hold: valid=%b out=%0d ready=%b required 1/16/0", ev[0], eo[0], sr[0]);
    end
    @(negedge clk);
    er[0] = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (ev[0] !== 1'b0 || sr[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: valid=%b ready=%b required 0/1", ev[0], sr[0]);
    end
    @(posedge clk); #1;
    sv[0] = 1'b0;
    n_tests++;
    if (sr[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_b2b_accept: ready=%b required 0", sr[0]);
    end
    l = 0;
    while (!ev[0] && l < 50) begin @(posedge clk); #1; l++; end
    n_tests++;
    if (eo[0] !== 32'd25 || l != 3) begin
      n_fail++;
      $display("FAIL bp_second: out=%0d lat=%0d required 25/3", eo[0], l);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    sv[1] = 1'b1; xd[1] = 32'd7; nd[1] = 8'd200;
    @(posedge clk); #1;
    sv[1] = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (ev[1] !== 1'b0 || sr[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b ready=%b required 0/1", ev[1], sr[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    directed(1, 32'd2, 10, 32'd1024, 11, 1'b0);
  endtask

  task automatic test_random(input int d, input int count);
    logic [31:0] x;
    logic [31:0] r;
    int          n;
    int          l;
    bit          o;
    int          bad;
    bad = 0;
    for (int i = 0; i < count; i++) begin
      x = $urandom;
      if (i % 4 == 0) x = 32'($urandom_range(0, 5));
      n = $urandom_range(0, 255);
      if (i % 3 == 0) n = $urandom_range(0, 24);
      transact(d, x, n, 1'b1, r, l, o);
      n_tests++;
      if (r !== model_pow(x, n) || l != exp_lat(d, n)) begin
        n_fail++;
        $display("FAIL random[%0d] %0d^%0d: out=0x%08h lat=%0d required 0x%08h lat=%0d",
                 d, x, n, r, l, model_pow(x, n), exp_lat(d, n));
      end
`ifdef POW_OVF_FLAG_EN
      n_tests++;
      if (o !== model_ovf(x, n)) begin
        n_fail++;
        $display("FAIL random_ovf[%0d] %0d^%0d: got %b required %b", d, x, n, o, model_ovf(x, n));
      end
`endif
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      sv[d] = 1'b0; xd[d] = '0; nd[d] = '0; er[d] = 1'b1;
    end
    test_reset();
    test_basic();
    test_pow3();
    test_max_exp();
    test_backpressure();
    test_reset_mid();
    test_random(0, 1000);
    test_random(1, 100);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
